// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite scheduler.
package sprite_pkg;

    localparam int unsigned CORDW       = 16;
    localparam int unsigned IMGW        = 4;
    localparam int unsigned H_RES       = 640;
    localparam int unsigned V_TOTAL_DEF = 525;

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
        logic [IMGW-1:0]  img;
        logic             vis;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// CPU write port, line timing inputs and sprite-slot outputs of the scheduler.
interface sprite_scheduler_if #(
    parameter int unsigned N_ENT  = 16,
    parameter int unsigned N_SLOT = 4
);
    localparam int unsigned AW = $clog2(N_ENT);
    localparam int unsigned CW = sprite_pkg::CORDW;
    localparam int unsigned IW = sprite_pkg::IMGW;

    logic                 h_bright;
    logic [CW-1:0]        sy;
    logic                 frame_commit;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [CW-1:0]        wr_x;
    logic [CW-1:0]        wr_y;
    logic [IW-1:0]        wr_img;
    logic                 wr_vis;
    logic [N_SLOT*CW-1:0] slot_x;
    logic [N_SLOT*CW-1:0] slot_y;
    logic [N_SLOT*IW-1:0] slot_img;
    logic [N_SLOT-1:0]    slot_valid;
    logic                 overflow;
    logic                 scan_late;
    logic                 busy;

    modport master (
        output h_bright, sy, frame_commit, wr_en, wr_addr, wr_x, wr_y, wr_img, wr_vis,
        input  slot_x, slot_y, slot_img, slot_valid, overflow, scan_late, busy
    );

    modport slave (
        input  h_bright, sy, frame_commit, wr_en, wr_addr, wr_x, wr_y, wr_img, wr_vis,
        output slot_x, slot_y, slot_img, slot_valid, overflow, scan_late, busy
    );

endinterface

// File: rtl/sprite_attr_table.sv
// Shadow/active sprite attribute tables: CPU writes shadow, commit bulk-copies to active.
module sprite_attr_table
    import sprite_pkg::*;
#(
    parameter int unsigned N_ENT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [$clog2(N_ENT)-1:0] i_wr_addr,
    input  entry_t                   i_wr_ent,
    input  logic                     i_commit,
    input  logic [$clog2(N_ENT)-1:0] i_rd_addr,
    output entry_t                   o_rd_ent
);

    entry_t r_shadow [N_ENT];
    entry_t r_active [N_ENT];

    // Copy reads pre-write shadow, so a same-cycle write lands in shadow only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
        end else begin
            if (i_commit) r_active <= r_shadow;
            if (i_wr_en)  r_shadow[i_wr_addr] <= i_wr_ent;
        end
    end

    assign o_rd_ent = r_active[i_rd_addr];

endmodule

// File: rtl/sprite_scheduler.sv
// Scans the active attribute table during h-blank and loads the first N_SLOT hits into slots.
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int unsigned N_ENT      = 16,
    parameter int unsigned N_SLOT     = 4,
    parameter int unsigned SPR_HEIGHT = 8,
    parameter int unsigned SPR_SCALE  = 0,
    parameter int unsigned V_TOTAL    = V_TOTAL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    sprite_scheduler_if.slave bus
);

    localparam int unsigned AW   = $clog2(N_ENT);
    localparam int unsigned CNTW = $clog2(N_SLOT + 1);
    localparam int unsigned SIW  = $clog2(N_SLOT);
    localparam int unsigned SPAN = SPR_HEIGHT << SPR_SCALE;

    state_t                  r_state;
    logic                    r_hb_prev;
    logic                    r_commit_pend;
    logic [CORDW-1:0]        r_tgt;
    logic [AW-1:0]           r_ptr;
    logic [CNTW-1:0]         r_cnt;
    entry_t                  r_work [N_SLOT];
    logic [N_SLOT*CORDW-1:0] r_slot_x;
    logic [N_SLOT*CORDW-1:0] r_slot_y;
    logic [N_SLOT*IMGW-1:0]  r_slot_img;
    logic [N_SLOT-1:0]       r_slot_valid;
    logic                    r_overflow;
    logic                    r_scan_late;
    logic                    r_busy;

    entry_t                  w_ent;
    entry_t                  w_wr_ent;
    logic [CORDW-1:0]        w_tgt;
    logic [CORDW:0]          w_d;
    logic                    w_hit;
    logic                    w_fall;
    logic                    w_copy;

    assign w_wr_ent = '{x: bus.wr_x, y: bus.wr_y, img: bus.wr_img, vis: bus.wr_vis};
    assign w_tgt    = (bus.sy == CORDW'(V_TOTAL - 1)) ? '0 : bus.sy + CORDW'(1);
    // Sign-extended difference so sprites above the top edge still hit.
    assign w_d      = {r_tgt[CORDW-1], r_tgt} - {w_ent.y[CORDW-1], w_ent.y};
    assign w_hit    = w_ent.vis && !w_d[CORDW] && (w_d < (CORDW+1)'(SPAN));
    assign w_fall   = r_hb_prev && !bus.h_bright;
    assign w_copy   = (r_state == ST_IDLE) && (bus.frame_commit || r_commit_pend);

    sprite_attr_table #(.N_ENT(N_ENT)) u_table (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_ent  (w_wr_ent),
        .i_commit  (w_copy),
        .i_rd_addr (r_ptr),
        .o_rd_ent  (w_ent)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_hb_prev     <= 1'b0;
            r_commit_pend <= 1'b0;
            r_tgt         <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_work        <= '{default: '0};
            r_slot_x      <= '0;
            r_slot_y      <= '0;
            r_slot_img    <= '0;
            r_slot_valid  <= '0;
            r_overflow    <= 1'b0;
            r_scan_late   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_hb_prev <= bus.h_bright;
            if (w_copy) begin
                r_commit_pend <= 1'b0;
                r_overflow    <= 1'b0;
                r_scan_late   <= 1'b0;
            end else if (bus.frame_commit) begin
                r_commit_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                        r_tgt   <= w_tgt;
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                        r_work  <= '{default: '0};
                    end
                end
                ST_SCAN: begin
                    if (bus.h_bright) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_scan_late  <= 1'b1;
                        r_slot_valid <= '0;
                    end else begin
                        if (w_hit) begin
                            if (r_cnt < CNTW'(N_SLOT)) begin
                                r_work[r_cnt[SIW-1:0]] <= w_ent;
                                r_cnt                  <= r_cnt + CNTW'(1);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (r_ptr == AW'(N_ENT - 1)) r_state <= ST_COMMIT;
                        else                         r_ptr   <= r_ptr + AW'(1);
                    end
                end
                ST_COMMIT: begin
                    for (int unsigned k = 0; k < N_SLOT; k++) begin
                        r_slot_x[k*CORDW +: CORDW] <= r_work[k].x;
                        r_slot_y[k*CORDW +: CORDW] <= r_work[k].y;
                        r_slot_img[k*IMGW +: IMGW] <= r_work[k].img;
                        r_slot_valid[k]            <= (CNTW'(k) < r_cnt);
                    end
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.slot_x     = r_slot_x;
    assign bus.slot_y     = r_slot_y;
    assign bus.slot_img   = r_slot_img;
    assign bus.slot_valid = r_slot_valid;
    assign bus.overflow   = r_overflow;
    assign bus.scan_late  = r_scan_late;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed scoreboard bench: a 1x-scale and a 2x-scale scheduler share one stimulus stream.
module tb_sprite_scheduler;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_scheduler_if #(.N_ENT(16), .N_SLOT(4)) ifa ();
    sprite_scheduler_if #(.N_ENT(16), .N_SLOT(4)) ifb ();

    assign ifb.h_bright     = ifa.h_bright;
    assign ifb.sy           = ifa.sy;
    assign ifb.frame_commit = ifa.frame_commit;
    assign ifb.wr_en        = ifa.wr_en;
    assign ifb.wr_addr      = ifa.wr_addr;
    assign ifb.wr_x         = ifa.wr_x;
    assign ifb.wr_y         = ifa.wr_y;
    assign ifb.wr_img       = ifa.wr_img;
    assign ifb.wr_vis       = ifa.wr_vis;

    sprite_scheduler dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
    sprite_scheduler #(.SPR_SCALE(1)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  img;
        logic        vis;
    } ment_t;

    typedef struct {
        int          dut;
        string       tag;
        logic [3:0]  valid;
        logic [63:0] x;
        logic [63:0] y;
        logic [15:0] img;
        logic        ovf;
        logic        late;
        logic        pos;
    } exp_t;

    ment_t m_shadow [16];
    ment_t m_active [16];
    bit    m_ovf  [2];
    bit    m_late [2];
    exp_t  sbq [$];
    int    total = 0;
    int    bad   = 0;
    logic [3:0] last_valid_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear_flags();
        for (int d = 0; d < 2; d++) begin
            m_ovf[d]  = 1'b0;
            m_late[d] = 1'b0;
        end
    endtask

    task automatic drive_wr(input int a, input int x, input int y, input int img, input bit vis);
        ifa.wr_en   = 1'b1;
        ifa.wr_addr = 4'(a);
        ifa.wr_x    = 16'(x);
        ifa.wr_y    = 16'(y);
        ifa.wr_img  = 4'(img);
        ifa.wr_vis  = vis;
    endtask

    task automatic wr(input int a, input int x, input int y, input int img, input bit vis);
        drive_wr(a, x, y, img, vis);
        tick();
        ifa.wr_en = 1'b0;
        m_shadow[a] = '{x: 16'(x), y: 16'(y), img: 4'(img), vis: vis};
    endtask

    task automatic commit();
        ifa.frame_commit = 1'b1;
        tick();
        ifa.frame_commit = 1'b0;
        m_active = m_shadow;
        model_clear_flags();
    endtask

    task automatic commit_wr(input int a, input int x, input int y, input int img, input bit vis);
        drive_wr(a, x, y, img, vis);
        ifa.frame_commit = 1'b1;
        tick();
        ifa.frame_commit = 1'b0;
        ifa.wr_en        = 1'b0;
        m_active    = m_shadow;
        m_shadow[a] = '{x: 16'(x), y: 16'(y), img: 4'(img), vis: vis};
        model_clear_flags();
    endtask

    // Reference model of one line's selection; pushes the expected slot state.
    task automatic predict(input int d, input int sy, input string tag, input bit abort);
        exp_t e;
        int   tgt, span, cnt, dd;
        tgt  = (sy == 524) ? 0 : sy + 1;
        span = (d == 1) ? 16 : 8;
        cnt  = 0;
        e.dut = d; e.tag = tag; e.valid = '0; e.x = '0; e.y = '0; e.img = '0; e.pos = !abort;
        if (abort) begin
            m_late[d] = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                dd = tgt - int'($signed(m_active[i].y));
                if (m_active[i].vis && dd >= 0 && dd < span) begin
                    if (cnt < 4) begin
                        e.valid[cnt]        = 1'b1;
                        e.x[cnt*16 +: 16]   = m_active[i].x;
                        e.y[cnt*16 +: 16]   = m_active[i].y;
                        e.img[cnt*4 +: 4]   = m_active[i].img;
                        cnt++;
                    end else begin
                        m_ovf[d] = 1'b1;
                    end
                end
            end
        end
        e.ovf  = m_ovf[d];
        e.late = m_late[d];
        sbq.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.dut == 0) begin
                last_valid_a = e.valid;
                cmp({e.tag, "_a_valid"}, 64'(ifa.slot_valid), 64'(e.valid));
                if (e.pos) begin
                    cmp({e.tag, "_a_x"},   ifa.slot_x, e.x);
                    cmp({e.tag, "_a_y"},   ifa.slot_y, e.y);
                    cmp({e.tag, "_a_img"}, 64'(ifa.slot_img), 64'(e.img));
                end
                cmp({e.tag, "_a_ovf"},  64'(ifa.overflow),  64'(e.ovf));
                cmp({e.tag, "_a_late"}, 64'(ifa.scan_late), 64'(e.late));
            end else begin
                cmp({e.tag, "_b_valid"}, 64'(ifb.slot_valid), 64'(e.valid));
                if (e.pos) begin
                    cmp({e.tag, "_b_x"},   ifb.slot_x, e.x);
                    cmp({e.tag, "_b_img"}, 64'(ifb.slot_img), 64'(e.img));
                end
                cmp({e.tag, "_b_ovf"},  64'(ifb.overflow),  64'(e.ovf));
                cmp({e.tag, "_b_late"}, 64'(ifb.scan_late), 64'(e.late));
            end
        end
    endtask

    task automatic scan(input int sy, input string tag, input bit mid_commit);
        ifa.sy       = 16'(sy);
        ifa.h_bright = 1'b1;
        tick();
        ifa.h_bright = 1'b0;
        predict(0, sy, tag, 1'b0);
        predict(1, sy, tag, 1'b0);
        for (int i = 0; i < 18; i++) begin
            ifa.frame_commit = mid_commit && (i == 3);
            tick();
            if (i == 16) cmp({tag, "_busy_hi"}, 64'(ifa.busy), 64'd1);
        end
        ifa.frame_commit = 1'b0;
        cmp({tag, "_busy_lo"}, 64'(ifa.busy), 64'd0);
        check_pop();
        ifa.h_bright = 1'b1;
        tick();
        cmp({tag, "_stable"}, 64'(ifa.slot_valid), 64'(last_valid_a));
        if (mid_commit) begin
            m_active = m_shadow;
            model_clear_flags();
            cmp({tag, "_pend_ovf_clr"}, 64'(ifa.overflow), 64'd0);
        end
    endtask

    task automatic abort_scan(input int sy, input string tag);
        ifa.sy       = 16'(sy);
        ifa.h_bright = 1'b1;
        tick();
        ifa.h_bright = 1'b0;
        predict(0, sy, tag, 1'b1);
        predict(1, sy, tag, 1'b1);
        repeat (5) tick();
        ifa.h_bright = 1'b1;
        tick();
        check_pop();
        cmp({tag, "_busy"}, 64'(ifa.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifa.h_bright = 1'b1; ifa.sy = '0; ifa.frame_commit = 1'b0;
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_x = '0; ifa.wr_y = '0;
        ifa.wr_img = '0; ifa.wr_vis = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = '{x: '0, y: '0, img: '0, vis: 1'b0};
            m_active[i] = '{x: '0, y: '0, img: '0, vis: 1'b0};
        end
        model_clear_flags();
        repeat (3) tick();
        cmp("rst_valid", 64'(ifa.slot_valid), 64'd0);
        cmp("rst_x", ifa.slot_x, 64'd0);
        cmp("rst_img", 64'(ifa.slot_img), 64'd0);
        cmp("rst_ovf", 64'(ifa.overflow), 64'd0);
        cmp("rst_late", 64'(ifa.scan_late), 64'd0);
        cmp("rst_busy", 64'(ifa.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // single sprite
        wr(0, 100, 50, 3, 1'b1);
        commit();
        scan(49, "single", 1'b0);
        cmp("single_x0_const", 64'(ifa.slot_x[15:0]), 64'd100);
        cmp("single_img0_const", 64'(ifa.slot_img[3:0]), 64'd3);

        // six hits on one line
        for (int i = 0; i < 6; i++) wr(i, 10 * i + 1, 10, i, 1'b1);
        commit();
        scan(9, "ovf", 1'b0);
        cmp("ovf_valid_const", 64'(ifa.slot_valid), 64'hF);
        cmp("ovf_flag_const", 64'(ifa.overflow), 64'd1);
        commit();
        cmp("ovf_cleared", 64'(ifa.overflow), 64'd0);

        // vertical span edges at 1x and 2x
        wr(0, 20, 10, 1, 1'b1);
        for (int i = 1; i < 6; i++) wr(i, 0, 0, 0, 1'b0);
        commit();
        scan(24, "span25", 1'b0);
        cmp("span25_b_const", 64'(ifb.slot_valid), 64'd1);
        scan(25, "span26", 1'b0);
        wr(0, 5, -4, 2, 1'b1);
        commit();
        scan(-1, "neg4", 1'b0);
        wr(0, 5, -8, 2, 1'b1);
        commit();
        scan(-1, "neg8", 1'b0);
        cmp("neg8_a_const", 64'(ifa.slot_valid), 64'd0);

        // last line wraps to line 0
        wr(0, 9, 0, 6, 1'b1);
        commit();
        scan(524, "wrap", 1'b0);
        cmp("wrap_const", 64'(ifa.slot_valid), 64'd1);
        scan(523, "nowrap", 1'b0);

        // write coincident with commit stays in shadow
        commit_wr(2, 7, 30, 5, 1'b1);
        scan(29, "wrcommit", 1'b0);
        commit();
        scan(29, "wrcommit2", 1'b0);

        // commit arriving mid-scan is deferred
        for (int i = 3; i < 8; i++) wr(i, 50 + i, 40, i, 1'b1);
        commit();
        wr(1, 77, 40, 9, 1'b1);
        scan(39, "pend", 1'b1);
        scan(39, "pend2", 1'b0);

        // late scan abort
        abort_scan(100, "abort");
        commit();
        cmp("late_cleared", 64'(ifa.scan_late), 64'd0);

        // reset in the middle of a scan
        ifa.sy = 16'd49;
        ifa.h_bright = 1'b1;
        tick();
        ifa.h_bright = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        cmp("mrst_busy", 64'(ifa.busy), 64'd0);
        cmp("mrst_valid", 64'(ifa.slot_valid), 64'd0);
        cmp("mrst_x", ifa.slot_x, 64'd0);
        cmp("mrst_ovf", 64'(ifa.overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = '{x: '0, y: '0, img: '0, vis: 1'b0};
            m_active[i] = '{x: '0, y: '0, img: '0, vis: 1'b0};
        end
        model_clear_flags();
        ifa.h_bright = 1'b1;
        rst_n = 1'b1;
        tick();
        scan(49, "postrst", 1'b0);

        cmp("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
